contador_13_a_0: RTL and testbench

Synchronous modulo-14 down-counter, the descending counterpart of the team's 0-to-13 up-counter. It counts 13, 12, … 0 and either wraps back to 13 or halts, depending on mode. It offers synchronous load, count enable, a terminal-count pulse, a saturating wrap counter and optional BCD digits for the board's 7-segment displays.

---
 rtl/contador_pkg.sv | 17 +
 rtl/contador_13_a_0_bin2bcd.sv | 21 ++
 rtl/contador_13_a_0.sv | 134 +++++++++++++
 tb/tb_contador_13_a_0.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// contador_pkg: shared types and default constants for the modulo-14
// down-counter family.
//   cnt_state_t : counter FSM states (RUN, HOLD, DONE)
//   CNT_MAX     : default start/wrap value
//   CNT_WIDTH   : default count width
package contador_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } cnt_state_t;

  localparam int CNT_MAX   = 13;
  localparam int CNT_WIDTH = 4;

endpackage

// File: rtl/contador_13_a_0_bin2bcd.sv
// bin2bcd_0_15: combinational conversion of a 4-bit binary value (0..15)
// into two BCD digits.
//   bin   in  4  binary value
//   tens  out 4  tens digit (0 or 1)
//   units out 4  units digit (0..9)
module bin2bcd_0_15 (
  input  logic [3:0] bin,
  output logic [3:0] tens,
  output logic [3:0] units
);

  always_comb begin
    tens  = 4'd0;
    units = bin;
    if (bin >= 4'd10) begin
      tens  = 4'd1;
      units = bin - 4'd10;
    end
  end

endmodule

// File: rtl/contador_13_a_0.sv
// contador_13_a_0: modulo-(MAX+1) down-counter. Counts MAX..0 and either
// wraps back to MAX or halts at 0 (DONE) depending on oneshot. Provides a
// synchronous load (clamped to MAX), count enable, a registered terminal-count
// pulse, a saturating wrap counter and optional registered BCD digits.
//
// Optional feature macro: CONTADOR_13_A_0_BCD_EN
//   defined   : bcd_tens/bcd_units carry the registered digits of q
//   undefined : both digit ports are tied to 0, no conversion logic
//
// Ports:
//   clk       in  1       clock, rising edge
//   rst       in  1       asynchronous active-high reset
//   en        in  1       count enable
//   load      in  1       synchronous load strobe (priority over en)
//   load_val  in  WIDTH   load value, clamped to MAX
//   oneshot   in  1       1 = halt at 0, 0 = wrap to MAX
//   q         out WIDTH   current count
//   tc        out 1       one-cycle pulse on wrap or on entering DONE
//   done      out 1       high while in DONE
//   wraps     out WRAP_W  saturating count of wraps since reset
//   bcd_tens  out 4       tens digit of q
//   bcd_units out 4       units digit of q
//
// state | meaning
// RUN   | counting, decrement on each enabled cycle
// HOLD  | en low, q frozen; en high resumes and decrements in that cycle
// DONE  | oneshot reached 0; q held at 0, en ignored until load or rst
module contador_13_a_0
  import contador_pkg::*;
#(
  parameter int MAX    = CNT_MAX,
  parameter int WIDTH  = CNT_WIDTH,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              oneshot,
  output logic [WIDTH-1:0]  q,
  output logic              tc,
  output logic              done,
  output logic [WRAP_W-1:0] wraps,
  output logic [3:0]        bcd_tens,
  output logic [3:0]        bcd_units
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX);

  cnt_state_t        state, state_n;
  logic [WIDTH-1:0]  q_n;
  logic              tc_n;
  logic [WRAP_W-1:0] wraps_n;

  always_comb begin
    state_n = state;
    q_n     = q;
    tc_n    = 1'b0;
    wraps_n = wraps;
    if (load) begin
      q_n     = (load_val > MAX_Q) ? MAX_Q : load_val;
      state_n = RUN;
    end else begin
      case (state)
        RUN, HOLD: begin
          if (en) begin
            state_n = RUN;
            if (q == '0) begin
              tc_n = 1'b1;
              if (oneshot) begin
                state_n = DONE;
              end else begin
                q_n = MAX_Q;
                if (wraps != '1)
                  wraps_n = wraps + WRAP_W'(1);
              end
            end else begin
              q_n = q - WIDTH'(1);
            end
          end else begin
            state_n = HOLD;
          end
        end
        DONE:    state_n = DONE;
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      q     <= MAX_Q;
      tc    <= 1'b0;
      done  <= 1'b0;
      wraps <= '0;
    end else begin
      state <= state_n;
      q     <= q_n;
      tc    <= tc_n;
      done  <= (state_n == DONE);
      wraps <= wraps_n;
    end
  end

`ifdef CONTADOR_13_A_0_BCD_EN
  localparam logic [3:0] MAX_TENS  = (MAX >= 10) ? 4'd1 : 4'd0;
  localparam logic [3:0] MAX_UNITS = (MAX >= 10) ? 4'(MAX - 10) : 4'(MAX);

  logic [3:0] tens_n, units_n;

  // Converted from next-q so the digits land on the same edge as q.
  bin2bcd_0_15 u_bcd (
    .bin   (4'(q_n)),
    .tens  (tens_n),
    .units (units_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_tens  <= MAX_TENS;
      bcd_units <= MAX_UNITS;
    end else begin
      bcd_tens  <= tens_n;
      bcd_units <= units_n;
    end
  end
`else
  assign bcd_tens  = 4'd0;
  assign bcd_units = 4'd0;
`endif

endmodule

// File: tb/tb_contador_13_a_0.sv
module tb_contador_13_a_0;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, load, oneshot;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tc, done;
  logic [7:0] wraps;
  logic [3:0] bcd_tens, bcd_units;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       en;
    logic       load;
    logic [3:0] lv;
    logic       os;
    logic [3:0] q;
    logic       tc;
    logic       done;
    logic [7:0] wr;
  } vec_t;

  vec_t vecs[$];

  contador_13_a_0 dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .load_val  (load_val),
    .oneshot   (oneshot),
    .q         (q),
    .tc        (tc),
    .done      (done),
    .wraps     (wraps),
    .bcd_tens  (bcd_tens),
    .bcd_units (bcd_units)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic l, input logic [3:0] lv, input logic os,
                     input logic [3:0] eq, input logic etc, input logic edone, input logic [7:0] ewr);
    vec_t v;
    v.en = e; v.load = l; v.lv = lv; v.os = os;
    v.q = eq; v.tc = etc; v.done = edone; v.wr = ewr;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bcd(input int idx, input logic [3:0] eq);
`ifdef CONTADOR_13_A_0_BCD_EN
    chk("bcd_tens", idx, int'(bcd_tens), (eq >= 4'd10) ? 1 : 0);
    chk("bcd_units", idx, int'(bcd_units), (eq >= 4'd10) ? int'(eq) - 10 : int'(eq));
`else
    chk("bcd_tens", idx, int'(bcd_tens), 0);
    chk("bcd_units", idx, int'(bcd_units), 0);
`endif
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; load_val = 4'd0; oneshot = 1'b0;

    // Free-running wrap from reset: 12..0, then 13 with tc, then 12.
    for (int i = 0; i <= 12; i++) add(1, 0, 0, 0, 4'(12 - i), 0, 0, 0);
    add(1, 0, 0, 0, 13, 1, 0, 1);
    add(1, 0, 0, 0, 12, 0, 0, 1);
    // Hold and resume
    add(0, 0, 0, 0, 12, 0, 0, 1);
    add(0, 0, 0, 0, 12, 0, 0, 1);
    add(1, 0, 0, 0, 11, 0, 0, 1);
    // Load priority over en
    add(1, 1, 9, 0, 9, 0, 0, 1);
    add(1, 0, 0, 0, 8, 0, 0, 1);
    // Clamp, then hold 5 cycles, then resume
    add(0, 1, 15, 0, 13, 0, 0, 1);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 13, 0, 0, 1);
    add(1, 0, 0, 0, 12, 0, 0, 1);
    // Oneshot into DONE
    add(0, 1, 2, 0, 2, 0, 0, 1);
    add(1, 0, 0, 1, 1, 0, 0, 1);
    add(1, 0, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 1, 0, 1, 1, 1);
    add(1, 0, 0, 1, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1, 1);
    // Load leaves DONE
    add(1, 1, 5, 0, 5, 0, 0, 1);
    add(1, 0, 0, 0, 4, 0, 0, 1);
    add(0, 1, 1, 0, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 13, 1, 0, 2);
    // Load 0 with en: no wrap that cycle; HOLD at 0 then wrap on resume
    add(1, 1, 0, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 2);
    add(1, 0, 0, 0, 13, 1, 0, 3);
    // oneshot dropped just before the 0 crossing -> wrap
    add(0, 1, 1, 0, 1, 0, 0, 3);
    add(1, 0, 0, 1, 0, 0, 0, 3);
    add(1, 0, 0, 0, 13, 1, 0, 4);
    add(0, 1, 10, 0, 10, 0, 0, 4);
    add(1, 0, 0, 0, 9, 0, 0, 4);

    step(); step();
    rst = 1'b0;
    #2;
    chk("rst_q", 0, int'(q), 13);
    chk("rst_tc", 0, int'(tc), 0);
    chk("rst_done", 0, int'(done), 0);
    chk("rst_wraps", 0, int'(wraps), 0);
    chk_bcd(0, 4'd13);

    foreach (vecs[i]) begin
      en = vecs[i].en; load = vecs[i].load; load_val = vecs[i].lv; oneshot = vecs[i].os;
      step();
      chk("q", i, int'(q), int'(vecs[i].q));
      chk("tc", i, int'(tc), int'(vecs[i].tc));
      chk("done", i, int'(done), int'(vecs[i].done));
      chk("wraps", i, int'(wraps), int'(vecs[i].wr));
      chk_bcd(i, vecs[i].q);
    end

    // Asynchronous reset mid-count at q=6
    en = 1'b1; load = 1'b0; oneshot = 1'b0;
    step(); step(); step();
    chk("pre_arst_q", 0, int'(q), 6);
    #3 rst = 1'b1;
    #1;
    chk("arst_q", 0, int'(q), 13);
    chk("arst_wraps", 0, int'(wraps), 0);
    chk("arst_tc", 0, int'(tc), 0);
    chk("arst_done", 0, int'(done), 0);
    chk_bcd(100, 4'd13);
    #1 rst = 1'b0;
    step();
    chk("post_arst_q", 0, int'(q), 12);

    // Saturation: from q=13 the k-th wrap lands on edge 14k.
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    for (int n = 1; n <= 3569; n++) step();
    chk("wraps_254", 0, int'(wraps), 254);
    chk("q_before_255", 0, int'(q), 0);
    step();
    chk("wraps_255", 0, int'(wraps), 255);
    chk("tc_255", 0, int'(tc), 1);
    chk("q_255", 0, int'(q), 13);
    for (int n = 0; n < 700; n++) step();
    chk("wraps_sat", 0, int'(wraps), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
